// File: rtl/conv_enc_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional encoder: default
// generators, constraint length, FSM state encoding and the tap parity helper.
package conv_enc_pkg;

  localparam logic [2:0] CONV_G0 = 3'b111;
  localparam logic [2:0] CONV_G1 = 3'b101;
  localparam int         CONV_K  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    DRAIN = 2'b10
  } conv_enc_state_t;

  // Parity of the generator-selected taps; taps are {current, s1, s2}.
  function automatic logic conv_parity(input logic [2:0] g, input logic [2:0] taps);
    conv_parity = ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder trellis core: 2-bit shift state plus generator parity, with a
// registered output symbol. Shared with the decoder's reference model.
module conv_enc_core
  import conv_enc_pkg::*;
#(
  parameter logic [2:0] G0 = CONV_G0,
  parameter logic [2:0] G1 = CONV_G1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b,
  input  logic       step,
  input  logic       clr,
  output logic [1:0] sym
);

  logic [CONV_K-2:0] r_st;
  logic [1:0]        r_sym;
  logic [CONV_K-1:0] w_taps;
  logic [1:0]        w_sym;

  assign w_taps = {b, r_st};
  assign w_sym  = {conv_parity(G0, w_taps), conv_parity(G1, w_taps)};

  // Trellis state and symbol register; clear takes priority over a step.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_st  <= {(CONV_K-1){1'b0}};
      r_sym <= 2'b00;
    end else if (step) begin
      r_st  <= {b, r_st[CONV_K-2:1]};
      r_sym <= w_sym;
    end else begin
      r_st  <= r_st;
      r_sym <= r_sym;
    end
  end

  assign sym = r_sym;

endmodule

// File: rtl/conv_encoder.sv
// Frame-level convolutional encoder feeding the Viterbi decoder, one symbol per
// data_ack rising edge. Define CONV_ENC_TAIL_EN to append two zero tail bits.
module conv_encoder
  import conv_enc_pkg::*;
#(
  parameter int         MSG_W = 10,
  parameter logic [2:0] G0    = CONV_G0,
  parameter logic [2:0] G1    = CONV_G1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MSG_W-1:0] msg,
  input  logic             msg_valid,
  output logic             msg_ready,
  output logic [1:0]       sym,
  output logic             seq_rdy,
  input  logic             data_ack
);

`ifdef CONV_ENC_TAIL_EN
  localparam int N_SYM = MSG_W + 2;
`else
  localparam int N_SYM = MSG_W;
`endif
  localparam int               CNT_W    = $clog2(MSG_W + 3);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SYM - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SEND  = SEND;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_ack_q;
  logic             r_seq_rdy;
  logic [MSG_W-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;

  logic w_edge;
  logic w_accept;
  logic w_step;
  logic w_clr;
  logic w_last;

  assign w_edge   = data_ack & ~r_ack_q;
  assign w_accept = msg_valid & (r_state == ST_IDLE);
  assign w_step   = w_edge & (r_state == ST_SEND);
  assign w_last   = (r_cnt == LAST_CNT);
  // The core is cleared on accept and on the end-of-frame ack, so sym is 00 in IDLE.
  assign w_clr    = w_accept | (w_edge & (r_state == ST_DRAIN));

  // Next-state logic for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (msg_valid) w_state_nxt = ST_SEND;
        else           w_state_nxt = ST_IDLE;
      end
      ST_SEND: begin
        if (w_edge && w_last) w_state_nxt = ST_DRAIN;
        else                  w_state_nxt = ST_SEND;
      end
      ST_DRAIN: begin
        if (w_edge) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, ack edge history, message shift register and symbol counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ack_q   <= 1'b0;
      r_seq_rdy <= 1'b0;
      r_shift   <= {MSG_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_ack_q   <= data_ack;
      r_seq_rdy <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_shift <= msg;
        r_cnt   <= {CNT_W{1'b0}};
      end else if (w_step) begin
        // Zero fill makes the tail bits fall out of the shifter for free.
        r_shift <= {r_shift[MSG_W-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_shift <= r_shift;
        r_cnt   <= r_cnt;
      end
    end
  end

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .b    (r_shift[MSG_W-1]),
    .step (w_step),
    .clr  (w_clr),
    .sym  (sym)
  );

  assign msg_ready = (r_state == ST_IDLE);
  assign seq_rdy   = r_seq_rdy;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: table of frames with hand-computed symbol
// streams plus short sequences for held acks, reset and back-to-back frames.
`timescale 1ns/1ps
module tb_conv_encoder;

  localparam int MSG_W = 10;
`ifdef CONV_ENC_TAIL_EN
  localparam int N_SYM = 12;
`else
  localparam int N_SYM = 10;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [MSG_W-1:0] msg;
  logic             msg_valid;
  logic             msg_ready;
  logic [1:0]       sym;
  logic             seq_rdy;
  logic             data_ack;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  msg;
    logic [23:0] syms;   // first symbol in [23:22], tail-enabled stream
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  conv_encoder #(.MSG_W(MSG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .msg       (msg),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .sym       (sym),
    .seq_rdy   (seq_rdy),
    .data_ack  (data_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_sym"}, 32'(sym), 32'h0);
    chk({name, "_seq_rdy"}, 32'(seq_rdy), 32'h0);
    chk({name, "_msg_ready"}, 32'(msg_ready), 32'h1);
  endtask

  // Offer a message for one cycle; it is accepted when the encoder is idle.
  task automatic send(input logic [9:0] m);
    msg       = m;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    chk("accept_seq_rdy", 32'(seq_rdy), 32'h1);
    chk("accept_msg_ready", 32'(msg_ready), 32'h0);
  endtask

  // One rising edge on data_ack, symbol compared one clock later.
  task automatic ack(input string name, input logic [1:0] exp_sym);
    data_ack = 1'b1;
    @(negedge clk);
    chk(name, 32'(sym), 32'(exp_sym));
    data_ack = 1'b0;
    @(negedge clk);
  endtask

  // End-of-frame acknowledge from DRAIN.
  task automatic drain_ack(input string name);
    chk({name, "_drain_seq_rdy"}, 32'(seq_rdy), 32'h1);
    chk({name, "_drain_msg_ready"}, 32'(msg_ready), 32'h0);
    data_ack = 1'b1;
    @(negedge clk);
    chk_idle({name, "_end"});
    data_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] s;
    vecs[0].msg  = 10'b1011000000;
    vecs[0].syms = {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11,
                    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1].msg  = 10'b0000000001;
    vecs[1].syms = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                    2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11};
    vecs[2].msg  = 10'b1111111111;
    vecs[2].syms = {2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                    2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    vecs[3].msg  = 10'b1000000000;
    vecs[3].syms = {2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00,
                    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    rst       = 1'b1;
    msg       = 10'b0;
    msg_valid = 1'b0;
    data_ack  = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Acks in IDLE must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      data_ack = 1'b1;
      @(negedge clk);
      chk_idle("idle_ack");
      data_ack = 1'b0;
      @(negedge clk);
    end

    // Table-driven frames.
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].msg);
      s = vecs[v].syms;
      for (int i = 0; i < N_SYM; i++) begin
        ack($sformatf("vec%0d_sym%0d", v, i), s[23-2*i -: 2]);
        chk("mid_msg_ready", 32'(msg_ready), 32'h0);
      end
      drain_ack($sformatf("vec%0d", v));
    end

    // Held-high ack: one advance only; a mid-frame message is ignored.
    send(10'b1011000000);
    data_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      msg       = 10'b1111111111;
      msg_valid = (c == 2);
      @(negedge clk);
      chk("held_sym", 32'(sym), 32'h3);
      chk("held_msg_ready", 32'(msg_ready), 32'h0);
    end
    msg_valid = 1'b0;
    data_ack  = 1'b0;
    @(negedge clk);
    ack("held_sym2", 2'b10);
    ack("held_sym3", 2'b00);
    ack("held_sym4", 2'b01);

    // Reset mid-frame abandons the frame.
    rst = 1'b1;
    @(negedge clk);
    chk_idle("midrst");
    rst = 1'b0;
    @(negedge clk);

    // Ack high during the accept cycle is not an edge, nor is the held level.
    msg       = 10'b1011000000;
    msg_valid = 1'b1;
    data_ack  = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    chk("acc_edge_sym", 32'(sym), 32'h0);
    chk("acc_edge_seq_rdy", 32'(seq_rdy), 32'h1);
    @(negedge clk);
    chk("acc_level_sym", 32'(sym), 32'h0);
    data_ack = 1'b0;
    @(negedge clk);
    s = vecs[0].syms;
    for (int i = 0; i < N_SYM; i++)
      ack($sformatf("postrst_sym%0d", i), s[23-2*i -: 2]);
    drain_ack("postrst");

    // Back-to-back frames with msg_valid held high.
    msg       = 10'b1011000000;
    msg_valid = 1'b1;
    @(negedge clk);
    chk("b2b_seq_rdy", 32'(seq_rdy), 32'h1);
    for (int i = 0; i < N_SYM; i++) begin
      ack($sformatf("b2b_sym%0d", i), s[23-2*i -: 2]);
      chk("b2b_mid_msg_ready", 32'(msg_ready), 32'h0);
    end
    data_ack = 1'b1;
    @(negedge clk);
    chk("b2b_gap_seq_rdy", 32'(seq_rdy), 32'h0);
    chk("b2b_gap_msg_ready", 32'(msg_ready), 32'h1);
    chk("b2b_gap_sym", 32'(sym), 32'h0);
    data_ack = 1'b0;
    @(negedge clk);
    chk("b2b_second_seq_rdy", 32'(seq_rdy), 32'h1);
    chk("b2b_second_msg_ready", 32'(msg_ready), 32'h0);
    msg_valid = 1'b0;
    ack("b2b_second_first_sym", 2'b11);

    rst = 1'b1;
    @(negedge clk);
    chk_idle("final_rst");
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
